mem_req_controller: RTL and testbench

MEM_REQ_CONTROLLER -- requirements
Module: mem_req_controller

---
 rtl/mem_req_pkg.sv | 27 ++
 rtl/mem_req_timer.sv | 42 ++++
 rtl/mem_req_controller.sv | 171 +++++++++++++++++
 tb/tb_mem_req_controller.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_pkg
// Description : Shared types and constants for the memory request controller:
//               controller state encoding, response error codes and the
//               default address/data widths and completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    // Response codes; any other value comes straight from the memory.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_timer
// Description : Completion-wait cycle counter. Held at zero while i_clear is
//               high, counts one per cycle while i_enable is high, and flags
//               o_expired during the cycle in which the count is TIMEOUT-1.
// Ports       : clk       - rising-edge clock
//               reset     - synchronous active-high reset
//               i_clear   - force count to zero
//               i_enable  - count this cycle
//               o_expired - count has reached TIMEOUT-1 (qualified by enable)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the last value so the counter never wraps back into range
    // if the enable were held beyond expiry.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_req_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_controller
// Description : Single-outstanding memory request controller. Accepts one
//               upstream read/write request, issues a one-cycle command strobe
//               when the memory is ready and not busy, waits for a completion
//               (or error, or timeout) and presents a held response until it
//               is accepted downstream.
// Ports       : clk, reset                 - clock, sync active-high reset
//               req_valid/req_ready        - upstream request handshake
//               req_write/req_addr/req_wdata - request operands
//               rsp_valid/rsp_ready        - downstream response handshake
//               rsp_rdata/rsp_error/rsp_code - response payload
//               mem_write_enable/mem_read_enable - one-cycle command strobes
//               mem_address/mem_write_data - command operands
//               mem_read_data, mem_ready, mem_busy, mem_valid, mem_error,
//               mem_error_code             - memory status inputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_controller
    import mem_req_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    // upstream request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // downstream response
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [1:0]        rsp_code,
    // memory command
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    // memory status
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    input  logic              mem_busy,
    input  logic              mem_valid,
    input  logic              mem_error,
    input  logic [1:0]        mem_error_code
);

    state_t            r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic [1:0]        r_rsp_code;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic w_accept;
    logic w_issue_go;
    logic w_expired;

    // req_ready is decoded from the state rather than registered so that it
    // drops while reset is held and rises in the very first cycle after.
    assign req_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;

    // The strobe must react to memory availability in the same cycle, so it
    // is decoded here; gating with reset stops a command escaping while an
    // in-flight transaction is being abandoned.
    assign w_issue_go       = (r_state == ST_ISSUE) && mem_ready && !mem_busy && !reset;
    assign mem_write_enable = w_issue_go && r_write;
    assign mem_read_enable  = w_issue_go && !r_write;

    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;

    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign rsp_code  = r_rsp_code;
    assign rsp_rdata = r_rsp_rdata;

    // Counter is held clear outside WAIT, so it reads zero on the first WAIT
    // cycle and counts every WAIT cycle after.
    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_code  <= ERR_NONE;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Holding registers only change on accept, so the command
                    // operands stay put through ISSUE, WAIT and RESP.
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (w_issue_go) begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Error beats a simultaneous valid; any completion beats
                    // the timeout landing in the same cycle.
                    if (mem_error) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_code  <= mem_error_code;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end else if (mem_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_code  <= ERR_NONE;
                        r_rsp_rdata <= r_write ? '0 : mem_read_data;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_code  <= ERR_TIMEOUT;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_rsp_code  <= ERR_NONE;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_controller
// Description : Self-checking bench for mem_req_controller. A driver issues
//               requests and plays the memory side; expected strobes and
//               responses are queued from a transaction-level model and
//               popped by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_controller;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic [1:0] rsp_code;
    logic       mem_write_enable;
    logic       mem_read_enable;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;
    logic       mem_ready;
    logic       mem_busy;
    logic       mem_valid;
    logic       mem_error;
    logic [1:0] mem_error_code;

    mem_req_controller #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .rsp_code         (rsp_code),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .mem_ready        (mem_ready),
        .mem_busy         (mem_busy),
        .mem_valid        (mem_valid),
        .mem_error        (mem_error),
        .mem_error_code   (mem_error_code)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } stb_t;

    typedef struct {
        logic       err;
        logic [1:0] code;
        logic [7:0] rdata;
        logic [7:0] addr;
        int         cyc;
    } rsp_t;

    stb_t sq[$];
    rsp_t rq[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int last_hs     = 0;
    int force_stall = 0;
    bit in_rsp      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %s, expected otherwise (cycle %0d)", name, what, cyc);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        mem_valid = 1'b0;
        mem_error = 1'b0;
        mem_busy  = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rq.delete();
        sq.delete();
        in_rsp = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_strobes"}, 32'({mem_write_enable, mem_read_enable}), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_write_data), 32'd0);
    endtask

    // Present a request and hold it until accepted.
    task automatic request(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, output bit ok);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        mem_ready = 1'b1;
        mem_busy  = 1'b0;
        mem_valid = 1'b0;
        mem_error = 1'b0;
        #1;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            fail_now("accept_wait", "no req_ready within 200 cycles");
            req_valid = 1'b0;
            do_reset();
            ok = 1'b0;
        end else begin
            // A held request is taken the cycle after the previous handshake.
            if (waited > 0) chk("b2b_accept_cycle", 32'(cyc), 32'(last_hs + 1));
            sq.push_back('{wr, addr, wdata});
            ok = 1'b1;
        end
    endtask

    // One transaction. blk = blocked ISSUE cycles, kind: 0 valid, 1 error,
    // 2 error+valid, 3 no completion; d = completion cycles after the strobe.
    task automatic txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input int blk, input int kind, input int d,
                       input logic [7:0] rd, input logic [1:0] ec);
        bit   ok;
        bit   win;
        logic act;
        int   s;
        int   n_c;
        rsp_t e;
        request(wr, addr, wdata, ok);
        if (!ok) return;
        for (int j = 0; j <= blk; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            if (j < blk) begin
                if ($urandom_range(0, 1) == 1) begin
                    mem_busy  = 1'b1;
                    mem_ready = 1'($urandom);
                end else begin
                    mem_ready = 1'b0;
                    mem_busy  = 1'($urandom);
                end
            end else begin
                mem_ready = 1'b1;
                mem_busy  = 1'b0;
            end
            // Completions outside WAIT must be ignored.
            mem_valid      = ($urandom_range(0, 3) == 0);
            mem_error      = ($urandom_range(0, 3) == 0);
            mem_error_code = 2'($urandom);
            mem_read_data  = 8'($urandom);
            #1;
            act = wr ? mem_write_enable : mem_read_enable;
            chk("strobe_timing", 32'(act), 32'(j == blk));
            if (act != (j == blk)) begin
                do_reset();
                return;
            end
        end
        s   = cyc;
        win = (kind != 3) && (d <= TIMEOUT);
        e.addr = addr;
        if (!win) begin
            e.err = 1'b1; e.code = 2'b11; e.rdata = 8'h00;
        end else if (kind == 0) begin
            e.err = 1'b0; e.code = 2'b00; e.rdata = wr ? 8'h00 : rd;
        end else begin
            e.err = 1'b1; e.code = ec; e.rdata = 8'h00;
        end
        e.cyc = s + (win ? d : TIMEOUT) + 1;
        rq.push_back(e);
        n_c = (kind == 3) ? 1 : d;
        for (int c = 1; c <= n_c; c++) begin
            @(negedge clk);
            mem_ready      = 1'b1;
            mem_busy       = 1'b0;
            mem_valid      = 1'b0;
            mem_error      = 1'b0;
            mem_read_data  = 8'($urandom);
            mem_error_code = 2'($urandom);
            if (kind != 3 && c == d) begin
                mem_valid      = (kind == 0 || kind == 2);
                mem_error      = (kind == 1 || kind == 2);
                mem_error_code = ec;
                mem_read_data  = rd;
            end
        end
        @(negedge clk);
        mem_valid = 1'b0;
        mem_error = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (rq.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() > 0) begin
            fail_now("drain", "responses still outstanding");
            do_reset();
        end
    endtask

    // Strobe monitor
    initial begin : mon_strobe
        stb_t s;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && (mem_write_enable || mem_read_enable)) begin
                chk("strobe_onehot", 32'(mem_write_enable && mem_read_enable), 32'd0);
                chk("strobe_mem_free", 32'(mem_ready && !mem_busy), 32'd1);
                if (sq.size() == 0) begin
                    fail_now("extra_strobe", "unexpected strobe");
                end else begin
                    s = sq.pop_front();
                    chk("strobe_dir", 32'(mem_write_enable), 32'(s.wr));
                    chk("strobe_addr", 32'(mem_address), 32'(s.addr));
                    if (s.wr) chk("strobe_wdata", 32'(mem_write_data), 32'(s.data));
                end
            end
        end
    end

    // Response monitor with randomised backpressure
    initial begin : mon_rsp
        rsp_t e;
        int   stall;
        stall     = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                rsp_ready = 1'b0;
                stall     = 0;
            end else begin
                if (in_rsp && !rsp_valid) begin
                    fail_now("rsp_dropped", "rsp_valid low before handshake");
                    in_rsp = 1'b0;
                end
                if (rsp_valid) begin
                    if (rq.size() == 0) begin
                        fail_now("unexpected_rsp", "rsp_valid with nothing outstanding");
                    end else begin
                        e = rq[0];
                        if (!in_rsp) begin
                            in_rsp = 1'b1;
                            chk("rsp_latency", 32'(cyc), 32'(e.cyc));
                            stall = force_stall;
                        end
                        chk("rsp_error", 32'(rsp_error), 32'(e.err));
                        chk("rsp_code", 32'(rsp_code), 32'(e.code));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                        chk("req_ready_in_rsp", 32'(req_ready), 32'd0);
                        chk("mem_address_held", 32'(mem_address), 32'(e.addr));
                    end
                    if (stall > 0) begin
                        rsp_ready = 1'b0;
                        stall--;
                    end else begin
                        rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (rsp_ready && rq.size() > 0) begin
                        void'(rq.pop_front());
                        in_rsp  = 1'b0;
                        last_hs = cyc;
                    end
                end else begin
                    rsp_ready = 1'($urandom);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit         ok;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
        logic [1:0] ec;
        int         blk;
        int         kind;
        int         d;
        int         r;

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_addr       = 8'h00;
        req_wdata      = 8'h00;
        mem_read_data  = 8'h00;
        mem_ready      = 1'b1;
        mem_busy       = 1'b0;
        mem_valid      = 1'b0;
        mem_error      = 1'b0;
        mem_error_code = 2'b00;

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Write 0x05 <= 0xAA, completion one cycle after the strobe
        txn(1'b1, 8'h05, 8'hAA, 0, 0, 1, 8'h77, 2'b00);
        drain();
        // Read 0x05 returning 0xAA, minimum latency
        txn(1'b0, 8'h05, 8'h00, 0, 0, 1, 8'hAA, 2'b00);
        drain();
        // Memory unavailable for 4 ISSUE cycles
        txn(1'b0, 8'h12, 8'h00, 4, 0, 1, 8'h3C, 2'b00);
        drain();
        // No completion in time; late mem_valid must be ignored
        txn(1'b0, 8'h40, 8'h00, 0, 0, 20, 8'h99, 2'b00);
        drain();
        // Completion on the last WAIT cycle wins; one later times out
        txn(1'b0, 8'h41, 8'h00, 0, 0, TIMEOUT, 8'h5A, 2'b00);
        drain();
        txn(1'b1, 8'h42, 8'h66, 0, 0, TIMEOUT + 1, 8'h00, 2'b00);
        drain();
        // Error together with valid, response held for 3 stalled cycles
        force_stall = 3;
        txn(1'b0, 8'h07, 8'h00, 0, 2, 2, 8'hEE, 2'b01);
        drain();
        force_stall = 0;

        // Reset while waiting for a completion
        request(1'b0, 8'h3C, 8'h00, ok);
        if (ok) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk("rst_case_strobe", 32'(mem_read_enable), 32'd1);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            #1;
            check_outputs_zero("mid_reset");
            reset = 1'b0;
            #1;
            chk("req_ready_after_mid_reset", 32'(req_ready), 32'd1);
            repeat (20) @(negedge clk);
        end
        txn(1'b1, 8'h81, 8'h18, 0, 0, 2, 8'h00, 2'b00);
        drain();

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            wr   = 1'($urandom);
            addr = 8'($urandom);
            wd   = 8'($urandom);
            rd   = 8'($urandom);
            ec   = 2'($urandom);
            blk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            r    = int'($urandom_range(0, 9));
            kind = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
            d    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                               : int'($urandom_range(1, 4));
            txn(wr, addr, wd, blk, kind, d, rd, ec);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
